turf_cmd_serializer: RTL and testbench



---
 rtl/turf_cmd_serializer.sv | 215 +++++++++++++++++++++
 tb/tb_turf_cmd_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_cmd_serializer.sv
// turf_cmd_serializer
// Queues accepted trigger events (32-bit event ID + 2-bit HOLD buffer number)
// and serializes each as one framed word onto the per-SURF CMD lines.
// Frame, MSB first: start(1), buf[1:0], id[31:0], optional odd parity, then
// GAP_BITS bit periods of forced low. Each bit lasts CLKS_PER_BIT clocks.
// Optional feature: define TURF_CMD_PARITY_EN to append an odd-parity bit
// after id[0], giving a 36-bit frame; otherwise the frame is 35 bits.
module turf_cmd_serializer #(
  parameter int NUM_SURFS    = 12,
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 evt_valid_i,
  output logic                 evt_ready_o,
  input  logic [31:0]          evt_id_i,
  input  logic [1:0]           evt_buf_i,
  input  logic [NUM_SURFS-1:0] surf_mask_i,
  output logic [NUM_SURFS-1:0] CMD_o,
  output logic                 busy_o,
  output logic [15:0]          sent_cnt_o,
  output logic                 overflow_o
);

`ifdef TURF_CMD_PARITY_EN
  localparam int FRAME_BITS = 36;
`else
  localparam int FRAME_BITS = 35;
`endif

  localparam int ENTRY_W   = 34;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int CLK_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W     = $clog2(FRAME_BITS);
  localparam int GAP_TOTAL = GAP_BITS * CLKS_PER_BIT;
  // CMD_o is registered, so the line drops one cycle after GAP is entered,
  // and LOAD adds one more low cycle before the next start bit. GAP itself
  // therefore lasts one cycle less than the low time seen on the wire.
  localparam int GAP_CYC   = (GAP_TOTAL > 1) ? GAP_TOTAL - 1 : 1;
  localparam int GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  push, pop;
  logic [ENTRY_W-1:0]    head;

  // Serializer state
  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [NUM_SURFS-1:0]  mask_q, mask_d;
  logic [CLK_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;

  // Registered outputs
  logic [NUM_SURFS-1:0]  cmd_q, cmd_d;
  logic                  busy_q, busy_d;
  logic [15:0]           sent_q, sent_d;
  logic                  overflow_q, overflow_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = evt_valid_i & ready_q;
  assign pop  = (state_q == ST_LOAD) && (count_q != '0);
  assign head = mem_q[rd_ptr_q];

  // FIFO next-state: pop and push resolve against the registered ready, so a
  // full FIFO refuses the write even if LOAD frees a slot in the same cycle.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {evt_buf_i, evt_id_i};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  // Framing FSM: LOAD pops and latches the mask, SHIFT walks the frame out,
  // GAP enforces the low interval and counts the completed frame.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    mask_d    = mask_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sent_d    = sent_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
`ifdef TURF_CMD_PARITY_EN
        shift_d = {1'b1, head, ~^head};
`else
        shift_d = {1'b1, head};
`endif
        mask_d    = surf_mask_i;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
          if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      default: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          sent_d  = sent_q + 16'd1;
          state_d = (count_q != '0) ? ST_LOAD : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
    endcase
  end

  // Output next-state: CMD lines mirror the shift MSB only while shifting,
  // gated per SURF by the mask captured at LOAD.
  always_comb begin
    cmd_d      = (state_q == ST_SHIFT) ? ({NUM_SURFS{shift_q[FRAME_BITS-1]}} & ~mask_q)
                                       : '0;
    busy_d     = (state_q != ST_IDLE) || (count_q != '0);
    overflow_d = overflow_q | (evt_valid_i & ~ready_q);
  end

  // FIFO payload storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      mask_q     <= '0;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
      sent_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      mask_q     <= mask_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_ready_o = ready_q;
  assign CMD_o       = cmd_q;
  assign busy_o      = busy_q;
  assign sent_cnt_o  = sent_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_turf_cmd_serializer.sv
// tb_turf_cmd_serializer
// Scoreboarded bench: each accepted event pushes its expected frame and mask;
// a monitor decodes frames off the CMD lines and pops/compares them.
module tb_turf_cmd_serializer;

  localparam int NS  = 12;
  localparam int CPB = 4;
  localparam int GB  = 4;
  localparam int FD  = 4;
`ifdef TURF_CMD_PARITY_EN
  localparam int FB = 36;
`else
  localparam int FB = 35;
`endif
  localparam int FRAME_CYC = FB * CPB;
  localparam int GAP_CYC   = GB * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          evt_valid = 1'b0;
  logic          evt_ready;
  logic [31:0]   evt_id = '0;
  logic [1:0]    evt_buf = '0;
  logic [NS-1:0] surf_mask = '0;
  logic [NS-1:0] cmd;
  logic          busy;
  logic [15:0]   sent_cnt;
  logic          overflow;

  typedef struct {
    logic [FB-1:0] frame;
    logic [NS-1:0] mask;
  } exp_t;

  exp_t  sb_q[$];
  int    starts[$];
  int    start_cnt = 0;
  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;
  int    wr_cyc = 0;
  int    exp_sent = 0;
  bit    in_frame = 0;
  bit    abort_frame = 0;

  turf_cmd_serializer #(
    .NUM_SURFS(NS), .CLKS_PER_BIT(CPB), .GAP_BITS(GB), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .evt_valid_i(evt_valid), .evt_ready_o(evt_ready),
    .evt_id_i(evt_id), .evt_buf_i(evt_buf), .surf_mask_i(surf_mask),
    .CMD_o(cmd), .busy_o(busy), .sent_cnt_o(sent_cnt), .overflow_o(overflow)
  );

  always #2 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FB-1:0] build_frame(input logic [1:0] b, input logic [31:0] id);
    logic [FB-1:0] f;
    int ones;
    ones = $countones({b, id});
`ifdef TURF_CMD_PARITY_EN
    f = {1'b1, b, id, ((ones % 2) == 0) ? 1'b1 : 1'b0};
`else
    f = {1'b1, b, id};
`endif
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drives one request for one clock; call just after a falling edge.
  task automatic applyStimulus(input logic [31:0] id, input logic [1:0] b,
                               input logic [NS-1:0] m, input bit accept);
    exp_t e;
    evt_valid = 1'b1;
    evt_id    = id;
    evt_buf   = b;
    if (accept) begin
      e.frame = build_frame(b, id);
      e.mask  = m;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 wr_cyc = cyc;
    @(negedge clk);
    evt_valid = 1'b0;
  endtask

  task automatic waitStarts(input int n, input int budget);
    for (int i = 0; i < budget && start_cnt < n; i++) @(negedge clk);
    checkOutput("start_wait", (start_cnt >= n), 1);
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget && (busy !== 1'b0 || sb_q.size() != 0 || in_frame); i++)
      @(negedge clk);
    checkOutput("idle_wait", (busy === 1'b0 && sb_q.size() == 0 && !in_frame), 1);
  endtask

  task automatic waitCycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic doReset(input bit mid_frame);
    @(negedge clk);
    rst = 1'b1;
    if (mid_frame) abort_frame = 1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single frame with latency and sent-count timing checks
  task automatic sendSingle(input logic [31:0] id, input logic [1:0] b);
    int n, s;
    n = start_cnt;
    applyStimulus(id, b, '0, 1);
    waitStarts(n + 1, 40);
    s = starts[starts.size() - 1];
    checkOutput("latency", s - wr_cyc, 3);
    waitCycle(s + FRAME_CYC);
    checkOutput("sent_before_gap", sent_cnt, exp_sent[15:0]);
    checkOutput("busy_in_gap", busy, 1);
    waitCycle(s + FRAME_CYC + GAP_CYC);
    exp_sent++;
    checkOutput("sent_after_gap", sent_cnt, exp_sent[15:0]);
    waitIdle(50);
  endtask

  // Frame monitor: decodes line NS-1 mid-bit, checks every line against the
  // expected mask each cycle, and confirms the line is low right after.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd[NS-1] === 1'b1) begin
        exp_t e;
        logic [FB-1:0] word;
        bit lines_bad, have, tail;
        in_frame  = 1;
        lines_bad = 0;
        word      = '0;
        starts.push_back(cyc);
        start_cnt++;
        have = (sb_q.size() > 0);
        if (have) e = sb_q[0];
        else begin
          e.frame = '0;
          e.mask  = '0;
        end
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (cmd !== ({NS{cmd[NS-1]}} & ~e.mask)) lines_bad = 1;
          if ((k % CPB) == (CPB / 2)) word = {word[FB-2:0], cmd[NS-1]};
        end
        @(negedge clk);
        tail = cmd[NS-1];
        if (abort_frame) abort_frame = 0;
        else begin
          checkOutput("frame_expected", have, 1);
          if (have) begin
            void'(sb_q.pop_front());
            checkOutput("frame_bits", word, e.frame);
            checkOutput("mask_lines", lines_bad, 0);
            checkOutput("frame_end_low", tail, 0);
          end
        end
        in_frame = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n0, n, s;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_ready", evt_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sent", sent_cnt, 0);
    checkOutput("rst_overflow", overflow, 0);

    $display("[TB] single frames");
    sendSingle(32'h0000_0001, 2'd2);
    sendSingle(32'hFFFF_FFFF, 2'd3);

    $display("[TB] back-to-back and overflow");
    n0 = start_cnt;
    applyStimulus(32'h1234_5678, 2'd1, '0, 1);
    waitStarts(n0 + 1, 40);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'hA000_0000 + i, 2'(i), '0, (i < 4));
      if (i == 3) begin
        checkOutput("ready_full", evt_ready, 0);
        checkOutput("overflow_clear", overflow, 0);
      end
    end
    checkOutput("overflow_set", overflow, 1);
    waitIdle(6 * (FRAME_CYC + GAP_CYC + 10));
    for (int j = n0; j < n0 + 4; j++)
      checkOutput("b2b_spacing", starts[j + 1] - starts[j], FRAME_CYC + GAP_CYC);
    exp_sent += 5;
    checkOutput("sent_b2b", sent_cnt, exp_sent[15:0]);
    checkOutput("overflow_sticky", overflow, 1);

    $display("[TB] mask change mid-frame");
    n = start_cnt;
    applyStimulus(32'h0F0F_0F0F, 2'd0, '0, 1);
    applyStimulus(32'h8000_0001, 2'd2, 12'h001, 1);
    waitStarts(n + 1, 40);
    surf_mask = 12'h001;
    waitIdle(3 * (FRAME_CYC + GAP_CYC + 10));
    surf_mask = '0;
    exp_sent += 2;
    checkOutput("sent_mask", sent_cnt, exp_sent[15:0]);

    $display("[TB] reset mid-frame");
    n = start_cnt;
    for (int i = 0; i < 3; i++) applyStimulus(32'hC0DE_0000 + i, 2'd3, '0, 1);
    waitStarts(n + 1, 40);
    s = starts[starts.size() - 1];
    waitCycle(s + 10 * CPB);
    doReset(1);
    checkOutput("mid_rst_cmd", cmd, 0);
    checkOutput("mid_rst_sent", sent_cnt, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_overflow", overflow, 0);
    checkOutput("mid_rst_ready", evt_ready, 1);
    exp_sent = 0;
    n = start_cnt;
    repeat (400) @(negedge clk);
    checkOutput("no_frames_after_rst", start_cnt, n);
    checkOutput("busy_after_rst", busy, 0);

    $display("[TB] random frames");
    for (int i = 0; i < 4; i++)
      sendSingle($urandom, 2'($urandom_range(0, 3)));

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
